// File: rtl/led_pkg.sv
// Shared constants and types for the LED mode selector and its key front end.
package led_pkg;

  localparam int unsigned LED_W              = 8;
  localparam int unsigned MODE_W             = 3;
  localparam int unsigned BASE_HZ            = 240000;
  localparam int unsigned DEBOUNCE_DEFAULT   = BASE_HZ / 50;  // 20 ms
  localparam int unsigned LONG_PRESS_DEFAULT = BASE_HZ * 2;   // 2 s

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } key_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus level debounce for an active-low key; flags the
// accepted press and release edges for one cycle.
module key_debounce
  import led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic stable_o,
  output logic press_p_o,
  output logic release_p_o
);

  localparam int unsigned            CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, key_s_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    flip     = 1'b0;
    if (key_s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      flip     = 1'b1;
      stable_d = key_s_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, which keeps the synchronizer a true two-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      key_s_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      key_s_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // The pulses are valid in the cycle before the flip edge, so a consumer
  // acts on the same edge that updates the stable level.
  assign stable_o    = stable_q;
  assign press_p_o   = flip & ~key_s_q;
  assign release_p_o = flip &  key_s_q;

endmodule

// File: rtl/led_mode_selector.sv
// Cycles the active LED mode on short key presses, returns to mode 0 on a long
// press, and muxes the selected driver bus onto the board LEDs.
module led_mode_selector
  import led_pkg::*;
#(
  parameter int unsigned NUM_MODES       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned LONG_PRESS      = LONG_PRESS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_n,
  input  logic [LED_W*NUM_MODES-1:0] mode_leds,
  output logic [LED_W-1:0]           led_out,
  output logic [MODE_W-1:0]          mode,
  output logic [NUM_MODES-1:0]       mode_en,
  output logic                       mode_changed
);

  localparam int unsigned        HOLD_W    = cnt_width(LONG_PRESS);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_PRESS - 1);
  localparam logic [MODE_W-1:0]  MODE_LAST = MODE_W'(NUM_MODES - 1);

  logic key_stable, press_p, release_p;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk        (clk),
    .rst        (rst),
    .key_n_i    (key_n),
    .stable_o   (key_stable),
    .press_p_o  (press_p),
    .release_p_o(release_p)
  );

  key_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [MODE_W-1:0]      mode_q, mode_d, mode_next;
  logic [NUM_MODES-1:0]   mode_en_q;
  logic [LED_W-1:0]       led_q, led_d, led_sel;
  logic                   changed_q, changed_d;

  assign mode_next = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (press_p) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (release_p) begin
          state_d = ST_IDLE;
          mode_d  = mode_next;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_LONG;
          mode_d  = '0;
        end else if (!key_stable) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_LONG: begin
        if (release_p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    led_sel = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode_q == MODE_W'(m)) led_sel = mode_leds[m*LED_W +: LED_W];
    end
  end

  // A mode change blanks the LEDs for one frame before the new bus appears.
  assign changed_d = (mode_d != mode_q);
  assign led_d     = changed_d ? '0 : led_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      mode_q    <= '0;
      mode_en_q <= NUM_MODES'(1);
      led_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      mode_q    <= mode_d;
      mode_en_q <= NUM_MODES'(1) << mode_d;
      led_q     <= led_d;
      changed_q <= changed_d;
    end
  end

  assign led_out      = led_q;
  assign mode         = mode_q;
  assign mode_en      = mode_en_q;
  assign mode_changed = changed_q;

endmodule

// File: tb/tb_led_mode_selector.sv
// Directed bench for led_mode_selector with short debounce and long-press times.
module tb_led_mode_selector;

  logic        clk;
  logic        rst;
  logic        key_n;
  logic [39:0] mode_leds;
  logic [7:0]  led_out;
  logic [2:0]  mode;
  logic [4:0]  mode_en;
  logic        mode_changed;

  int errors    = 0;
  int checks    = 0;
  int pulse_cnt = 0;
  int p0;
  int exp_seq[5] = '{1, 2, 3, 4, 0};

  led_mode_selector #(
    .NUM_MODES      (5),
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS     (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .mode_leds   (mode_leds),
    .led_out     (led_out),
    .mode        (mode),
    .mode_en     (mode_en),
    .mode_changed(mode_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mode_changed === 1'b1) pulse_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press long enough to debounce, release, and wait until the release is seen.
  task automatic short_press();
    key_n = 1'b0;
    ticks(8);
    key_n = 1'b1;
    ticks(6);
  endtask

  initial begin
    rst       = 1'b1;
    key_n     = 1'b1;
    mode_leds = 40'hEE_DD_CC_BB_AA;

    // 1: reset state, then mode 0 bus one cycle after reset falls
    ticks(3);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_mode_en", 32'(mode_en), 32'b00001);
    check("rst_led", 32'(led_out), 32'h00);
    check("rst_changed", 32'(mode_changed), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_led", 32'(led_out), 32'hAA);

    // 2: a 3-cycle glitch never debounces
    p0 = pulse_cnt;
    key_n = 1'b0;
    ticks(3);
    key_n = 1'b1;
    ticks(10);
    check("glitch_mode", 32'(mode), 32'd0);
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);

    // 3: short press advances exactly 6 cycles after the key rises
    p0 = pulse_cnt;
    key_n = 1'b0;
    ticks(10);
    key_n = 1'b1;
    ticks(5);
    check("short_mode_early", 32'(mode), 32'd0);
    tick();
    check("short_mode", 32'(mode), 32'd1);
    check("short_mode_en", 32'(mode_en), 32'b00010);
    check("short_changed", 32'(mode_changed), 32'd1);
    check("short_blank", 32'(led_out), 32'h00);
    tick();
    check("short_changed_drop", 32'(mode_changed), 32'd0);
    check("short_led", 32'(led_out), 32'hBB);
    ticks(2);
    check("short_pulses", 32'(pulse_cnt - p0), 32'd1);

    // 4: five presses from mode 0 wrap back to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("seq_start", 32'(mode), 32'd0);
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      short_press();
      check($sformatf("seq_mode_%0d", i), 32'(mode), 32'(exp_seq[i]));
      check($sformatf("seq_en_%0d", i), 32'(mode_en), 32'(5'b00001 << exp_seq[i]));
      ticks(2);
    end
    check("seq_pulses", 32'(pulse_cnt - p0), 32'd5);

    // 5: long press from mode 3 returns to 0 on the 20th cycle after press_p
    for (int i = 0; i < 3; i++) begin
      short_press();
      ticks(2);
    end
    check("long_start", 32'(mode), 32'd3);
    p0 = pulse_cnt;
    key_n = 1'b0;
    ticks(25);
    check("long_mode_early", 32'(mode), 32'd3);
    tick();
    check("long_mode", 32'(mode), 32'd0);
    check("long_mode_en", 32'(mode_en), 32'b00001);
    check("long_changed", 32'(mode_changed), 32'd1);
    ticks(14);
    key_n = 1'b1;
    ticks(10);
    check("long_release_mode", 32'(mode), 32'd0);
    check("long_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("long_led", 32'(led_out), 32'hAA);

    p0 = pulse_cnt;
    key_n = 1'b0;
    ticks(40);
    key_n = 1'b1;
    ticks(10);
    check("long0_mode", 32'(mode), 32'd0);
    check("long0_pulses", 32'(pulse_cnt - p0), 32'd0);

    // 6: reset just before the release is debounced cancels the advance
    short_press();
    ticks(2);
    check("rst_mid_start", 32'(mode), 32'd1);
    key_n = 1'b0;
    ticks(8);
    key_n = 1'b1;
    ticks(3);
    rst = 1'b1;
    ticks(2);
    check("rst_mid_mode", 32'(mode), 32'd0);
    check("rst_mid_en", 32'(mode_en), 32'b00001);
    check("rst_mid_changed", 32'(mode_changed), 32'd0);
    rst = 1'b0;
    p0 = pulse_cnt;
    ticks(10);
    check("rst_mid_after", 32'(mode), 32'd0);
    check("rst_mid_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("rst_mid_led", 32'(led_out), 32'hAA);

    // Key held through reset is debounced again as a fresh press
    key_n = 1'b0;
    ticks(8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(8);
    key_n = 1'b1;
    ticks(6);
    check("held_rst_mode", 32'(mode), 32'd1);
    ticks(2);
    check("held_rst_led", 32'(led_out), 32'hBB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
